// File: rtl/mio_axis_pkg.sv
// Shared definitions for the AXI4-Stream FIFO: default widths, the packet-mode
// state type and the packed beat width helper.
package mio_axis_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ID_WIDTH    = 4;
  localparam int DEF_DEST_WIDTH  = 4;
  localparam int DEF_USER_WIDTH  = 1;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_PACKET_MODE = 0;

  // WAIT holds output until a whole frame (or a full FIFO) is present; FWD forwards.
  typedef enum logic {WAIT, FWD} mio_axis_fifo_st_t;

  // Width of one stored beat: tdata + tstrb + tkeep + tlast + tid + tdest + tuser.
  function automatic int mio_axis_beat_width(input int dw, input int iw,
                                             input int dew, input int uw);
    return dw + 2 * (dw / 8) + 1 + iw + dew + uw;
  endfunction

endpackage

// File: rtl/mio_axis_fifo_ram.sv
// Beat storage: register array with one synchronous write port and one
// asynchronous read port so the head beat is visible without extra latency.
module mio_axis_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 50,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the incoming beat; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mio_axis_fifo.sv
// Synchronous AXI4-Stream FIFO with optional store-and-forward packet mode.
// Holds pointers, fill/packet counters, the release FSM and beat pack/unpack.
module mio_axis_fifo
  import mio_axis_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ID_WIDTH    = DEF_ID_WIDTH,
  parameter int DEST_WIDTH  = DEF_DEST_WIDTH,
  parameter int USER_WIDTH  = DEF_USER_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int PACKET_MODE = DEF_PACKET_MODE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [DATA_WIDTH-1:0]      s_tdata,
  input  logic [DATA_WIDTH/8-1:0]    s_tstrb,
  input  logic [DATA_WIDTH/8-1:0]    s_tkeep,
  input  logic                       s_tlast,
  input  logic [ID_WIDTH-1:0]        s_tid,
  input  logic [DEST_WIDTH-1:0]      s_tdest,
  input  logic [USER_WIDTH-1:0]      s_tuser,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [DATA_WIDTH-1:0]      m_tdata,
  output logic [DATA_WIDTH/8-1:0]    m_tstrb,
  output logic [DATA_WIDTH/8-1:0]    m_tkeep,
  output logic                       m_tlast,
  output logic [ID_WIDTH-1:0]        m_tid,
  output logic [DEST_WIDTH-1:0]      m_tdest,
  output logic [USER_WIDTH-1:0]      m_tuser,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [$clog2(DEPTH+1)-1:0] pkt_cnt
);

  localparam int BW = mio_axis_beat_width(DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] ONE  = LW'(1);

  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [LW-1:0]      level_reg;
  logic [LW-1:0]      level_next;
  logic [LW-1:0]      pkt_cnt_reg;
  logic [LW-1:0]      pkt_cnt_next;
  logic               s_tready_reg;
  mio_axis_fifo_st_t  state_reg;
  logic [BW-1:0]      wr_beat;
  logic [BW-1:0]      rd_beat;
  logic               push;
  logic               pop;

  assign wr_beat = {s_tuser, s_tdest, s_tid, s_tlast, s_tkeep, s_tstrb, s_tdata};
  assign {m_tuser, m_tdest, m_tid, m_tlast, m_tkeep, m_tstrb, m_tdata} = rd_beat;

  // In cut-through mode the FSM is ignored and any stored beat is offered.
  assign m_tvalid = (level_reg != '0) && ((PACKET_MODE == 0) || (state_reg == FWD));
  assign s_tready = s_tready_reg;
  assign level    = level_reg;
  assign pkt_cnt  = pkt_cnt_reg;

  // s_tready is registered, so a full FIFO refuses a push even when popping.
  assign push = s_tvalid & s_tready_reg;
  assign pop  = m_tvalid & m_tready;

  mio_axis_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (BW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_reg),
    .wdata (wr_beat),
    .raddr (rd_ptr_reg),
    .rdata (rd_beat)
  );

  // Next fill level and packet count; simultaneous inc and dec cancel out.
  always_comb begin
    level_next   = level_reg;
    pkt_cnt_next = pkt_cnt_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + ONE;
      2'b01:   level_next = level_reg - ONE;
      default: level_next = level_reg;
    endcase
    case ({push & s_tlast, pop & m_tlast})
      2'b10:   pkt_cnt_next = pkt_cnt_reg + ONE;
      2'b01:   pkt_cnt_next = pkt_cnt_reg - ONE;
      default: pkt_cnt_next = pkt_cnt_reg;
    endcase
  end

  // Pointers, counters and the registered ready flag; reset discards all beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      pkt_cnt_reg  <= '0;
      s_tready_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      level_reg    <= level_next;
      pkt_cnt_reg  <= pkt_cnt_next;
      s_tready_reg <= (level_next != FULL);
    end
  end

  // Release FSM: open on a complete frame or a full FIFO (oversize frame),
  // close after the tlast beat leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= WAIT;
    end else begin
      case (state_reg)
        WAIT: begin
          if ((PACKET_MODE != 0) && ((pkt_cnt_reg != '0) || (level_reg == FULL))) begin
            state_reg <= FWD;
          end
        end
        FWD: begin
          if (pop && m_tlast) begin
            state_reg <= WAIT;
          end
        end
        default: state_reg <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_axis_fifo.sv
// Directed bench for mio_axis_fifo: one cut-through and one packet-mode instance,
// each checked against a beat queue plus a small release-state model.
module tb_mio_axis_fifo;
  import mio_axis_pkg::*;

  logic clk;
  logic reset;

  // cut-through instance signals
  logic        s_tvalid_c, s_tready_c, s_tlast_c, s_tuser_c;
  logic [31:0] s_tdata_c;
  logic [3:0]  s_tstrb_c, s_tkeep_c, s_tid_c, s_tdest_c;
  logic        m_tvalid_c, m_tready_c, m_tlast_c, m_tuser_c;
  logic [31:0] m_tdata_c;
  logic [3:0]  m_tstrb_c, m_tkeep_c, m_tid_c, m_tdest_c;
  logic [4:0]  level_c, pkt_cnt_c;

  // packet-mode instance signals
  logic        s_tvalid_p, s_tready_p, s_tlast_p, s_tuser_p;
  logic [31:0] s_tdata_p;
  logic [3:0]  s_tstrb_p, s_tkeep_p, s_tid_p, s_tdest_p;
  logic        m_tvalid_p, m_tready_p, m_tlast_p, m_tuser_p;
  logic [31:0] m_tdata_p;
  logic [3:0]  m_tstrb_p, m_tkeep_p, m_tid_p, m_tdest_p;
  logic [4:0]  level_p, pkt_cnt_p;

  logic [49:0] m_beat_c, m_beat_p;
  assign m_beat_c = {m_tuser_c, m_tdest_c, m_tid_c, m_tlast_c, m_tkeep_c, m_tstrb_c, m_tdata_c};
  assign m_beat_p = {m_tuser_p, m_tdest_p, m_tid_p, m_tlast_p, m_tkeep_p, m_tstrb_p, m_tdata_p};

  int n_cmp = 0;
  int n_err = 0;
  logic [49:0] q_c[$];
  logic [49:0] q_p[$];
  bit fwd_m = 1'b0;

  mio_axis_fifo #(.PACKET_MODE(0)) dut_ct (
    .clk(clk), .reset(reset),
    .s_tvalid(s_tvalid_c), .s_tready(s_tready_c), .s_tdata(s_tdata_c), .s_tstrb(s_tstrb_c),
    .s_tkeep(s_tkeep_c), .s_tlast(s_tlast_c), .s_tid(s_tid_c), .s_tdest(s_tdest_c),
    .s_tuser(s_tuser_c),
    .m_tvalid(m_tvalid_c), .m_tready(m_tready_c), .m_tdata(m_tdata_c), .m_tstrb(m_tstrb_c),
    .m_tkeep(m_tkeep_c), .m_tlast(m_tlast_c), .m_tid(m_tid_c), .m_tdest(m_tdest_c),
    .m_tuser(m_tuser_c),
    .level(level_c), .pkt_cnt(pkt_cnt_c)
  );

  mio_axis_fifo #(.PACKET_MODE(1)) dut_pk (
    .clk(clk), .reset(reset),
    .s_tvalid(s_tvalid_p), .s_tready(s_tready_p), .s_tdata(s_tdata_p), .s_tstrb(s_tstrb_p),
    .s_tkeep(s_tkeep_p), .s_tlast(s_tlast_p), .s_tid(s_tid_p), .s_tdest(s_tdest_p),
    .s_tuser(s_tuser_p),
    .m_tvalid(m_tvalid_p), .m_tready(m_tready_p), .m_tdata(m_tdata_p), .m_tstrb(m_tstrb_p),
    .m_tkeep(m_tkeep_p), .m_tlast(m_tlast_p), .m_tid(m_tid_p), .m_tdest(m_tdest_p),
    .m_tuser(m_tuser_p),
    .level(level_p), .pkt_cnt(pkt_cnt_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Beat contents derived from an index: {user, dest, id, last, keep, strb, data}.
  function automatic logic [49:0] exp_beat(input int idx, input bit last);
    logic [31:0] v;
    v = idx;
    return {v[0], v[3:0] ^ 4'h5, v[3:0], last, ~v[3:0], v[3:0], 32'hA500_0000 ^ v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on the cut-through instance.
  task automatic cyc_ct(input bit v, input int idx, input bit last, input bit rdy);
    bit push, pop;
    int nl;
    {s_tuser_c, s_tdest_c, s_tid_c, s_tlast_c, s_tkeep_c, s_tstrb_c, s_tdata_c} = exp_beat(idx, last);
    s_tvalid_c = v;
    m_tready_c = rdy;
    push = v && (q_c.size() != 16);
    pop  = rdy && (q_c.size() != 0);
    chk("ct_s_tready", s_tready_c, q_c.size() != 16);
    chk("ct_m_tvalid", m_tvalid_c, q_c.size() != 0);
    if (q_c.size() != 0) chk("ct_head", m_beat_c, q_c[0]);
    @(posedge clk); #1;
    if (pop) void'(q_c.pop_front());
    if (push) q_c.push_back(exp_beat(idx, last));
    nl = 0;
    foreach (q_c[k]) nl += int'(q_c[k][40]);
    chk("ct_level", level_c, q_c.size());
    chk("ct_pkt_cnt", pkt_cnt_c, nl);
    $display("ct  v=%0b idx=%0d last=%0b rdy=%0b push=%0b pop=%0b level=%0d pkt_cnt=%0d",
             v, idx, last, rdy, push, pop, level_c, pkt_cnt_c);
  endtask

  // One cycle on the packet-mode instance; acc reports whether the beat was taken.
  task automatic cyc_pk(input bit v, input int idx, input bit last, input bit rdy, output bit acc);
    bit push, pop, exp_valid, nf;
    int nl_pre, size_pre, nl;
    {s_tuser_p, s_tdest_p, s_tid_p, s_tlast_p, s_tkeep_p, s_tstrb_p, s_tdata_p} = exp_beat(idx, last);
    s_tvalid_p = v;
    m_tready_p = rdy;
    size_pre = q_p.size();
    nl_pre = 0;
    foreach (q_p[k]) nl_pre += int'(q_p[k][40]);
    exp_valid = fwd_m && (size_pre != 0);
    push = v && (size_pre != 16);
    pop  = rdy && exp_valid;
    chk("pk_s_tready", s_tready_p, size_pre != 16);
    chk("pk_m_tvalid", m_tvalid_p, exp_valid);
    if (exp_valid) chk("pk_head", m_beat_p, q_p[0]);
    nf = fwd_m;
    if (!fwd_m) nf = (nl_pre != 0) || (size_pre == 16);
    else if (pop && q_p[0][40]) nf = 1'b0;
    @(posedge clk); #1;
    if (pop) void'(q_p.pop_front());
    if (push) q_p.push_back(exp_beat(idx, last));
    fwd_m = nf;
    nl = 0;
    foreach (q_p[k]) nl += int'(q_p[k][40]);
    chk("pk_level", level_p, q_p.size());
    chk("pk_pkt_cnt", pkt_cnt_p, nl);
    chk("pk_state", dut_pk.state_reg, fwd_m ? 64'd1 : 64'd0);
    acc = push;
    $display("pk  v=%0b idx=%0d last=%0b rdy=%0b push=%0b pop=%0b level=%0d pkt_cnt=%0d fwd=%0b",
             v, idx, last, rdy, push, pop, level_p, pkt_cnt_p, fwd_m);
  endtask

  initial begin
    bit acc;
    int idx;
    int guard;
    reset = 1'b1;
    s_tvalid_c = 1'b0; m_tready_c = 1'b0; s_tvalid_p = 1'b0; m_tready_p = 1'b0;
    {s_tuser_c, s_tdest_c, s_tid_c, s_tlast_c, s_tkeep_c, s_tstrb_c, s_tdata_c} = '0;
    {s_tuser_p, s_tdest_p, s_tid_p, s_tlast_p, s_tkeep_p, s_tstrb_p, s_tdata_p} = '0;

    // Reset held three cycles, then released.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ct_s_tready_in_reset", s_tready_c, 0);
    chk("rst_pk_s_tready_in_reset", s_tready_p, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ct_s_tready", s_tready_c, 1);
    chk("rst_ct_m_tvalid", m_tvalid_c, 0);
    chk("rst_ct_level", level_c, 0);
    chk("rst_ct_pkt_cnt", pkt_cnt_c, 0);
    chk("rst_pk_s_tready", s_tready_p, 1);
    chk("rst_pk_m_tvalid", m_tvalid_p, 0);
    chk("rst_pk_level", level_p, 0);

    // Fill to DEPTH with downstream stalled.
    for (int i = 0; i < 16; i++) cyc_ct(1'b1, i, (i % 4) == 3, 1'b0);
    chk("fill_level16", level_c, 16);
    chk("fill_s_tready0", s_tready_c, 0);
    // 17th beat is offered while full, then accepted once room appears.
    cyc_ct(1'b1, 16, 1'b0, 1'b0);
    cyc_ct(1'b1, 16, 1'b0, 1'b0);
    cyc_ct(1'b1, 16, 1'b0, 1'b1);
    cyc_ct(1'b1, 16, 1'b0, 1'b0);
    chk("fill_17th_kept", level_c, 16);
    // Drain down to 8 beats.
    for (int i = 0; i < 8; i++) cyc_ct(1'b0, 0, 1'b0, 1'b1);
    chk("stream_start_level8", level_c, 8);
    // Streaming: push and pop every cycle, level must hold at 8.
    for (int k = 0; k < 100; k++) cyc_ct(1'b1, 17 + k, (k % 5) == 4, 1'b1);
    chk("stream_end_level8", level_c, 8);
    for (int i = 0; i < 8; i++) cyc_ct(1'b0, 0, 1'b0, 1'b1);
    cyc_ct(1'b0, 0, 1'b0, 1'b1);
    s_tvalid_c = 1'b0; m_tready_c = 1'b0;

    // Packet mode, normal frame of four beats.
    for (int i = 0; i < 3; i++) cyc_pk(1'b1, 50 + i, 1'b0, 1'b0, acc);
    chk("pk_norm_hold", m_tvalid_p, 0);
    cyc_pk(1'b1, 53, 1'b1, 1'b0, acc);
    chk("pk_norm_pkt_cnt1", pkt_cnt_p, 1);
    cyc_pk(1'b0, 0, 1'b0, 1'b1, acc);
    chk("pk_norm_release", m_tvalid_p, 1);
    for (int i = 0; i < 4; i++) cyc_pk(1'b0, 0, 1'b0, 1'b1, acc);
    chk("pk_norm_pkt_cnt0", pkt_cnt_p, 0);
    chk("pk_norm_wait", dut_pk.state_reg, 0);
    cyc_pk(1'b0, 0, 1'b0, 1'b1, acc);

    // Packet mode, oversize frame: release at full, then trailing beats pass.
    for (int i = 0; i < 16; i++) cyc_pk(1'b1, 100 + i, 1'b0, 1'b1, acc);
    chk("pk_over_full", level_p, 16);
    idx = 116;
    guard = 0;
    while (idx < 118 && guard < 20) begin
      cyc_pk(1'b1, idx, 1'b0, 1'b1, acc);
      if (acc) idx++;
      guard++;
    end
    chk("pk_over_feed_done", idx, 118);
    guard = 0;
    while (q_p.size() != 0 && guard < 40) begin
      cyc_pk(1'b0, 0, 1'b0, 1'b1, acc);
      guard++;
    end
    chk("pk_over_drained", level_p, 0);
    cyc_pk(1'b0, 0, 1'b0, 1'b1, acc);
    chk("pk_over_fwd_empty_valid", m_tvalid_p, 0);
    chk("pk_over_fwd_hold", dut_pk.state_reg, 1);
    cyc_pk(1'b1, 118, 1'b1, 1'b0, acc);
    chk("pk_over_tail_valid", m_tvalid_p, 1);
    cyc_pk(1'b0, 0, 1'b0, 1'b1, acc);
    cyc_pk(1'b0, 0, 1'b0, 1'b1, acc);
    chk("pk_over_end_valid", m_tvalid_p, 0);
    chk("pk_over_end_wait", dut_pk.state_reg, 0);
    s_tvalid_p = 1'b0; m_tready_p = 1'b0;

    // Reset mid-frame on the cut-through instance.
    for (int i = 0; i < 5; i++) cyc_ct(1'b1, 200 + i, 1'b0, 1'b0);
    chk("midrst_level5", level_c, 5);
    s_tvalid_c = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    q_c.delete();
    q_p.delete();
    fwd_m = 1'b0;
    chk("midrst_level0", level_c, 0);
    chk("midrst_m_tvalid0", m_tvalid_c, 0);
    chk("midrst_s_tready0", s_tready_c, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_s_tready1", s_tready_c, 1);
    cyc_ct(1'b1, 300, 1'b1, 1'b0);
    chk("midrst_new_beat", m_beat_c, exp_beat(300, 1'b1));
    cyc_ct(1'b0, 0, 1'b0, 1'b1);
    cyc_ct(1'b0, 0, 1'b0, 1'b0);
    chk("midrst_empty", m_tvalid_c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
